// File: rtl/out_pkg.sv
// Shared constants and types for the out_undd display unit.
// Segment patterns are gfedcba, active-low.
package out_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/out_undd_seg7_dec.sv
// BCD nibble to active-low 7-segment pattern.
// Non-decimal nibbles and blanked digits render dark.
module seg7_dec
  import out_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && bcd <= 4'd9)
      seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/out_undd.sv
// Output display unit: captures dado on controleOUT and shows it in decimal.
// Define OUT_SIGNED_EN to treat dado as two's complement with a sign digit.
module out_undd
  import out_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  controleOUT,
  input  logic [DATA_W-1:0]     dado,
  output logic                  ocupado,
  output logic                  valido,
  output logic [DIGITS*7-1:0]   hex,
  output logic [6:0]            hex_sinal
);

  localparam int CW = cnt_w(DATA_W);
  localparam int BW = DIGITS * 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t              state;
  logic [DATA_W-1:0]   bin;
  logic [DATA_W-1:0]   pend_val;
  logic                pend;
  logic [BW-1:0]       bcd;
  logic [BW-1:0]       adj;
  logic [CW-1:0]       cnt;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS*7-1:0] seg_nxt;
  logic                lead;

`ifdef OUT_SIGNED_EN
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);
  logic neg;
`endif

  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // Blank every digit above the top nonzero one; units always shown.
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead     = lead & (bcd[4*i +: 4] == 4'd0);
      blank[i] = lead;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_dec u_dec (
      .bcd   (bcd[4*g +: 4]),
      .blank (blank[g]),
      .seg   (seg_nxt[7*g +: 7])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bin      <= '0;
      pend_val <= '0;
      pend     <= 1'b0;
      bcd      <= '0;
      cnt      <= '0;
      ocupado  <= 1'b0;
      valido   <= 1'b0;
      hex      <= {DIGITS{SEG_BLANK}};
`ifdef OUT_SIGNED_EN
      neg       <= 1'b0;
      hex_sinal <= SEG_BLANK;
`endif
    end else begin
      if (controleOUT && state != IDLE) begin
        pend_val <= dado;
        pend     <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (controleOUT) begin
            bin     <= dado;
            ocupado <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          bcd   <= '0;
          cnt   <= CNT_LOAD;
          state <= SHIFT;
`ifdef OUT_SIGNED_EN
          neg <= bin[DATA_W-1];
          if (bin[DATA_W-1])
            bin <= ~bin + ONE;
`endif
        end
        SHIFT: begin
          {bcd, bin} <= {adj, bin} << 1;
          cnt        <= cnt - CNT_ONE;
          if (cnt == CNT_ONE)
            state <= DONE;
        end
        DONE: begin
          hex    <= seg_nxt;
          valido <= 1'b1;
`ifdef OUT_SIGNED_EN
          hex_sinal <= neg ? SEG_MINUS : SEG_BLANK;
`endif
          // A strobe landing in DONE is the newest request.
          if (controleOUT) begin
            bin   <= dado;
            pend  <= 1'b0;
            state <= LOAD;
          end else if (pend) begin
            bin   <= pend_val;
            pend  <= 1'b0;
            state <= LOAD;
          end else begin
            ocupado <= 1'b0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

`ifndef OUT_SIGNED_EN
  assign hex_sinal = SEG_BLANK;
`endif

endmodule

// File: tb/tb_out_undd.sv
// Randomized and directed bench for out_undd against a decimal model.
module tb_out_undd;

  localparam int DATA_W = 16;
  localparam int DIGITS = 5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  controleOUT = 1'b0;
  logic [DATA_W-1:0]     dado = '0;
  logic                  ocupado;
  logic                  valido;
  logic [DIGITS*7-1:0]   hex;
  logic [6:0]            hex_sinal;

  int checks = 0;
  int failures = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  localparam logic [DIGITS*7-1:0] ALL_BLANK = {DIGITS{7'h7F}};

  out_undd #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .controleOUT (controleOUT),
    .dado        (dado),
    .ocupado     (ocupado),
    .valido      (valido),
    .hex         (hex),
    .hex_sinal   (hex_sinal)
  );

  always #5 clk = ~clk;

  function automatic int mag(input logic [DATA_W-1:0] v);
    int m;
    m = int'(v);
`ifdef OUT_SIGNED_EN
    if (v[DATA_W-1]) m = (1 << DATA_W) - int'(v);
`endif
    return m;
  endfunction

  function automatic logic [DIGITS*7-1:0] m_hex(input logic [DATA_W-1:0] v);
    logic [DIGITS*7-1:0] r;
    int m;
    int p;
    m = mag(v);
    p = 1;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i > 0 && m < p) r[7*i +: 7] = 7'h7F;
      else r[7*i +: 7] = seg_tab[(m / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] m_sin(input logic [DATA_W-1:0] v);
`ifdef OUT_SIGNED_EN
    return v[DATA_W-1] ? 7'h3F : 7'h7F;
`else
    if (v == '0) return 7'h7F;
    return 7'h7F;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [DATA_W-1:0] v);
    @(negedge clk);
    dado = v;
    controleOUT = 1'b1;
    @(negedge clk);
    controleOUT = 1'b0;
  endtask

  task automatic wait_idle(output int cyc, output int chg, output bit to);
    logic [DIGITS*7-1:0] h0;
    h0 = hex;
    cyc = 0;
    chg = 0;
    to = 1'b0;
    while (ocupado) begin
      @(negedge clk);
      cyc++;
      if (ocupado && hex !== h0) chg++;
      if (cyc > 200) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_hex_change(input logic [DIGITS*7-1:0] h0,
                                 output bit to);
    int n;
    n = 0;
    to = 1'b0;
    while (hex === h0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic show(input string tag, input logic [DATA_W-1:0] v);
    int cyc, chg;
    bit to;
    strobe(v);
    wait_idle(cyc, chg, to);
    chg = chg;
    chk({tag, "_timeout"}, 64'(to), 64'd0);
    chk({tag, "_hex"}, 64'(hex), 64'(m_hex(v)));
    chk({tag, "_sign"}, 64'(hex_sinal), 64'(m_sin(v)));
  endtask

  initial begin
    int cyc, chg, k;
    bit to;
    logic [DATA_W-1:0] v1, v2;
    logic [DIGITS*7-1:0] h0;

    repeat (3) @(negedge clk);
    chk("rst_hex", 64'(hex), 64'(ALL_BLANK));
    chk("rst_sign", 64'(hex_sinal), 64'h7F);
    chk("rst_ocupado", 64'(ocupado), 64'd0);
    chk("rst_valido", 64'(valido), 64'd0);
    rst = 1'b0;
    chg = 0;
    repeat (50) begin
      @(negedge clk);
      if (hex !== ALL_BLANK || ocupado || valido || hex_sinal !== 7'h7F)
        chg++;
    end
    chk("idle_hold", 64'(chg), 64'd0);

    strobe(16'd1234);
    chk("busy_after_strobe", 64'(ocupado), 64'd1);
    wait_idle(cyc, chg, to);
    chk("busy_cycles", 64'(cyc), 64'd18);
    chk("no_intermediate", 64'(chg), 64'd0);
    chk("d1234_hex", 64'(hex), 64'(m_hex(16'd1234)));
    chk("d1234_lit", 64'(hex), 64'({7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}));
    chk("d1234_valido", 64'(valido), 64'd1);

    show("zero", 16'd0);
    chk("zero_digit0", 64'(hex[6:0]), 64'h40);
    show("max", 16'd65535);
    show("neg1", 16'hFFFF);
    show("minneg", 16'h8000);
    show("zero2", 16'd0);

    // Back-to-back: 65535, then 7 overwritten by 42 while busy.
    h0 = hex;
    @(negedge clk);
    dado = 16'd65535;
    controleOUT = 1'b1;
    @(negedge clk);
    controleOUT = 1'b0;
    repeat (2) @(negedge clk);
    dado = 16'd7;
    controleOUT = 1'b1;
    @(negedge clk);
    dado = 16'd42;
    @(negedge clk);
    controleOUT = 1'b0;
    wait_hex_change(h0, to);
    chk("b2b_first_to", 64'(to), 64'd0);
    chk("b2b_first", 64'(hex), 64'(m_hex(16'd65535)));
    chk("b2b_still_busy", 64'(ocupado), 64'd1);
    h0 = hex;
    wait_idle(cyc, chg, to);
    chk("b2b_idle_to", 64'(to), 64'd0);
    chk("b2b_no_seven", 64'(chg), 64'd0);
    chk("b2b_second", 64'(hex), 64'(m_hex(16'd42)));
    repeat (20) @(negedge clk);
    chk("b2b_stable", 64'(hex), 64'(m_hex(16'd42)));
    chk("b2b_stable_busy", 64'(ocupado), 64'd0);

    strobe(16'd999);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_hex", 64'(hex), 64'(ALL_BLANK));
    chk("midrst_busy", 64'(ocupado), 64'd0);
    chk("midrst_valido", 64'(valido), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_hold_hex", 64'(hex), 64'(ALL_BLANK));
    chk("midrst_hold_busy", 64'(ocupado), 64'd0);

    for (int n = 0; n < 24; n++) begin
      v1 = DATA_W'($urandom);
      v2 = v1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      strobe(v1);
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, 16);
        repeat (k) @(negedge clk);
        v2 = DATA_W'($urandom);
        strobe(v2);
      end
      wait_idle(cyc, chg, to);
      chk("rnd_timeout", 64'(to), 64'd0);
      chk("rnd_hex", 64'(hex), 64'(m_hex(v2)));
      chk("rnd_sign", 64'(hex_sinal), 64'(m_sin(v2)));
      chk("rnd_valido", 64'(valido), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
